// File: rtl/var_delay_line_pkg.sv
// Shared tracking-channel constants for the variable delay line: default depth,
// pointer width, FSM state encodings and the delay clamp helper.
package var_delay_line_pkg;

  localparam int GPS_MAX_DELAY  = 64;
  localparam int GPS_ADDR_WIDTH = 6;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Map a requested delay onto the legal range 1..max_delay.
  function automatic logic [31:0] clamp_delay(input logic [31:0] sel,
                                              input logic [31:0] max_delay);
    logic [31:0] d;
    if (sel == 32'd0) begin
      d = 32'd1;
    end else if (sel > max_delay) begin
      d = max_delay;
    end else begin
      d = sel;
    end
    return d;
  endfunction

endpackage

// File: rtl/var_delay_line_delay_ram.sv
// Sample history store: one synchronous write port and one asynchronous read
// port, sized to map onto distributed RAM.
module delay_ram #(
  parameter int WIDTH      = 1,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/var_delay_line.sv
// Runtime-programmable sample delay: circular buffer with a write pointer and an
// offset reader, gated until enough history exists for the selected delay.
module var_delay_line
  import var_delay_line_pkg::*;
#(
  parameter int WIDTH         = 1,
  parameter int MAX_DELAY     = GPS_MAX_DELAY,
  parameter int ADDR_WIDTH    = GPS_ADDR_WIDTH,
  parameter int DEFAULT_DELAY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in,
  input  logic                  delay_load,
  input  logic [ADDR_WIDTH:0]   delay_sel,
  output logic [WIDTH-1:0]      out,
  output logic                  out_valid,
  output logic                  busy
);

  localparam int D_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] FILL_MAX = ADDR_WIDTH'(MAX_DELAY - 1);
  localparam logic [D_W-1:0] D_RESET = D_W'(DEFAULT_DELAY);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] fill;
  logic [ADDR_WIDTH-1:0] fill_next;
  logic [D_W-1:0]        d_reg;
  logic [D_W-1:0]        d_sel_clamped;
  logic [D_W-1:0]        d_eff;
  logic [D_W-1:0]        d_minus;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [WIDTH-1:0]      rd_data;
  logic [0:0]            state;
  logic [0:0]            state_next;
  logic                  history_ok;
  logic                  emit;

  // A delay loaded in the same cycle as a sample already governs that sample.
  assign d_sel_clamped = D_W'(clamp_delay(32'(delay_sel), 32'(MAX_DELAY)));
  assign d_eff         = delay_load ? d_sel_clamped : d_reg;
  assign d_minus       = d_eff - D_W'(1);
  assign rd_addr       = wr_ptr - d_minus[ADDR_WIDTH-1:0];

  // History is judged on fill before the current sample; FILL/RUN is a
  // registered view of the same test including this cycle's sample.
  assign history_ok = ({1'b0, fill} >= d_minus);
  assign emit       = in_valid && history_ok;

  always_comb begin
    fill_next = fill;
    if (in_valid && (fill != FILL_MAX)) begin
      fill_next = fill + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FILL: if ({1'b0, fill_next} >= d_minus) state_next = ST_RUN;
      ST_RUN:  if ({1'b0, fill_next} < d_minus)  state_next = ST_FILL;
      default: state_next = ST_FILL;
    endcase
  end

  delay_ram #(
    .WIDTH      (WIDTH),
    .DEPTH      (MAX_DELAY),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we      (in_valid),
    .wr_addr (wr_ptr),
    .wr_data (in),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      fill      <= '0;
      d_reg     <= D_RESET;
      state     <= ST_FILL;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (delay_load) begin
        d_reg <= d_sel_clamped;
      end
      if (in_valid) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      fill      <= fill_next;
      state     <= state_next;
      out_valid <= emit;
      // D=1 reads the slot being written this cycle, so take the input directly.
      if (emit) begin
        out <= (d_minus == '0) ? in : rd_data;
      end
    end
  end

  assign busy = (state == ST_FILL);

endmodule

// File: tb/tb_var_delay_line.sv
// Randomized and directed scoreboard bench for var_delay_line against a
// sample-history reference model.
module tb_var_delay_line;

  localparam int W    = 8;
  localparam int MAXD = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in = '0;
  logic         delay_load = 1'b0;
  logic [6:0]   delay_sel = '0;
  logic [W-1:0] out;
  logic         out_valid;
  logic         busy;

  var_delay_line #(.WIDTH(W), .MAX_DELAY(MAXD), .ADDR_WIDTH(6), .DEFAULT_DELAY(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
    .delay_load(delay_load), .delay_sel(delay_sel),
    .out(out), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [W-1:0] o;
    logic         b;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   hist[$];
  int   d_m = 1;
  int   last_out = 0;
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic int clampd(int s);
    if (s == 0) return 1;
    if (s > MAXD) return MAXD;
    return s;
  endfunction

  function automatic int fill_of(int n);
    return (n < MAXD - 1) ? n : MAXD - 1;
  endfunction

  task automatic chk(string name, int act, int req, int cyc);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, req);
    end
  endtask

  // Drive one cycle and push the outputs expected after the coming edge.
  task automatic step(bit rst, bit iv, int din, bit ld, int sel);
    exp_t e;
    int d, n;
    @(negedge clk);
    cycle++;
    reset = rst; in_valid = iv; in = W'(din); delay_load = ld; delay_sel = 7'(sel);
    e.cyc = cycle;
    if (rst) begin
      hist.delete();
      d_m = 1;
      last_out = 0;
      e.v = 1'b0; e.o = '0; e.b = 1'b1;
    end else begin
      d = ld ? clampd(sel) : d_m;
      d_m = d;
      n = hist.size();
      e.v = 1'b0;
      if (iv) begin
        hist.push_back(din & 8'hff);
        if (fill_of(n) >= d - 1) begin
          e.v = 1'b1;
          last_out = hist[n - d + 1];
        end
      end
      e.o = W'(last_out);
      e.b = !(fill_of(hist.size()) >= d - 1);
    end
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_valid", int'(out_valid), int'(e.v), e.cyc);
        chk("out", int'(out), int'(e.o), e.cyc);
        chk("busy", int'(busy), int'(e.b), e.cyc);
      end
    end
  end

  initial begin : driver
    // 1: default D=1
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, i, 0, 0);
    // 2: D=4 ramp
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, i, i == 0, 4);
    // 3: D=4 with in_valid toggling
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, (i % 2) == 0, i / 2, i == 0, 4);
    // 4: grow D from 4 to 8 with full history
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) step(0, 1, $urandom_range(0, 255), i == 0, 4);
    step(0, 1, $urandom_range(0, 255), 1, 8);
    for (int i = 0; i < 12; i++) step(0, 1, $urandom_range(0, 255), 0, 0);
    // 5: clamps
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, i + 40, i == 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 70; i++) step(0, 1, i, i == 0, MAXD + 5);
    // 6: reset mid-stream at D=8, then resume at D=1
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, i + 100, i == 0, 8);
    step(1, 1, 77, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, i + 200, 0, 0);
    // Random mix of gaps, reloads and occasional resets
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 255), $urandom_range(0, 19) == 0,
           $urandom_range(0, 80));
    end
    step(0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0, cycle);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
